// File: rtl/uart_pkg.sv
// Shared register map, bit positions, state encodings and helpers for the APB UART.
package uart_pkg;

  // Register word index (PADDR[4:2])
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STAT    = 3'd1;
  localparam logic [2:0] REG_TXDATA  = 3'd2;
  localparam logic [2:0] REG_RXDATA  = 3'd3;
  localparam logic [2:0] REG_BAUDDIV = 3'd4;
  localparam logic [2:0] REG_IRQEN   = 3'd5;
  localparam logic [2:0] REG_RXTHR   = 3'd6;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_PEN     = 1;
  localparam int unsigned CTRL_PODD    = 2;
  localparam int unsigned CTRL_STOP2   = 3;
  localparam int unsigned CTRL_WLEN    = 4;
  localparam int unsigned CTRL_TXFLUSH = 6;
  localparam int unsigned CTRL_RXFLUSH = 7;

  // STAT sticky-flag bit positions (W1C)
  localparam int unsigned STAT_PERR = 5;
  localparam int unsigned STAT_FERR = 6;
  localparam int unsigned STAT_OVR  = 7;

  // WLEN codes
  localparam logic [1:0] WLEN_5 = 2'd0;
  localparam logic [1:0] WLEN_6 = 2'd1;
  localparam logic [1:0] WLEN_7 = 2'd2;
  localparam logic [1:0] WLEN_8 = 2'd3;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Mask covering the active data bits of a frame
  function automatic logic [7:0] wlen_mask(input logic [1:0] wlen);
    return 8'hFF >> (3'd3 - 3'(wlen));
  endfunction

  // Parity bit to transmit: even = XOR of data bits, odd = its inverse
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wlen,
                                       input logic podd);
    return (^(data & wlen_mask(wlen))) ^ podd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with flush; push is accepted when full only if a pop happens the same cycle.
module uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy tracking; flush overrides any concurrent push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_ip.sv
// APB3 UART with TX/RX FIFOs, 16x-oversampled baud divider, parity, stop bits and level IRQs.
module uart_fifo_ip
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RST    = 16'd42,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [3:0]        PSTRB,
  input  logic              PSEL,
  input  logic              PENABLE,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irqs1_rxuart,
  output logic              irqs2_txuart,
  output logic              o_uart_tx,
  input  logic              i_uart_rx
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic en, pen, podd, stop2;
  logic [1:0]  wlen;
  logic [15:0] bauddiv, baud_cnt;
  logic [2:0]  irqen;
  logic [7:0]  rxthr;
  logic perr, ferr, ovr;
  logic [2:0]  reg_sel;
  logic access_c, slverr_c, wr_ok, rd_ok, tick, baud_wr_c, stat_w1c;
  logic [31:0] rd_val;

  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic [LVL_W-1:0] tx_level, rx_level;

  tx_state_t tx_state;
  logic [4:0] tx_tcnt;
  logic [2:0] tx_bcnt;
  logic [7:0] tx_shreg;
  logic [1:0] tx_wlen;
  logic tx_par, tx_pen, tx_stop2, tx_line, tbusy;
  logic tx_bit_end_c, tx_stop_end_c, tx_load_c;

  rx_state_t rx_state;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bcnt;
  logic [7:0] rx_shreg, rx_byte_c;
  logic [1:0] rx_wlen;
  logic rx_s1, rx_s2, rx_par, rx_pen, rx_podd;
  logic rx_mid_c, rx_stop_c, perr_set_c, ferr_set_c, ovr_set_c;

  logic unused_bits;
  assign unused_bits = ^{PADDR[ADDR_W-1:5], PADDR[1:0], PWDATA[DATA_W-1:16], PSTRB[3:2]};

  // APB decode and error response
  assign reg_sel   = PADDR[4:2];
  assign access_c  = PSEL & PENABLE;
  assign slverr_c  = access_c & ((reg_sel == 3'd7) ||
                                 (PWRITE && reg_sel == REG_TXDATA && tx_full) ||
                                 (!PWRITE && reg_sel == REG_RXDATA && rx_empty));
  assign wr_ok     = access_c & PWRITE & ~slverr_c;
  assign rd_ok     = access_c & ~PWRITE & ~slverr_c;
  assign PREADY    = 1'b1;
  assign PSLVERR   = slverr_c;
  assign PRDATA    = DATA_W'(rd_val);
  assign tx_push   = wr_ok & (reg_sel == REG_TXDATA) & PSTRB[0];
  assign tx_flush  = wr_ok & (reg_sel == REG_CTRL) & PSTRB[0] & PWDATA[CTRL_TXFLUSH];
  assign rx_flush  = wr_ok & (reg_sel == REG_CTRL) & PSTRB[0] & PWDATA[CTRL_RXFLUSH];
  assign rx_pop    = rd_ok & (reg_sel == REG_RXDATA);
  assign baud_wr_c = wr_ok & (reg_sel == REG_BAUDDIV);
  assign stat_w1c  = wr_ok & (reg_sel == REG_STAT) & PSTRB[0];
  assign tbusy     = (tx_state != TX_IDLE);

  // Combinational read mux; zero outside a valid read access
  always_comb begin
    rd_val = '0;
    if (rd_ok) begin
      case (reg_sel)
        REG_CTRL:    rd_val = {26'd0, wlen, stop2, podd, pen, en};
        REG_STAT:    rd_val = {8'd0, 8'(rx_level), 8'(tx_level), ovr, ferr, perr, tbusy,
                               rx_empty, rx_full, tx_empty, tx_full};
        REG_RXDATA:  rd_val = {24'd0, rx_head};
        REG_BAUDDIV: rd_val = {16'd0, bauddiv};
        REG_IRQEN:   rd_val = {29'd0, irqen};
        REG_RXTHR:   rd_val = {24'd0, rxthr};
        default:     rd_val = '0;
      endcase
    end
  end

  // Configuration registers with byte-lane strobes
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en <= 1'b0; pen <= 1'b0; podd <= 1'b0; stop2 <= 1'b0; wlen <= WLEN_8;
      bauddiv <= DIV_RST; irqen <= '0; rxthr <= 8'd1;
    end else if (wr_ok) begin
      case (reg_sel)
        REG_CTRL: if (PSTRB[0]) begin
          en    <= PWDATA[CTRL_EN];
          pen   <= PWDATA[CTRL_PEN];
          podd  <= PWDATA[CTRL_PODD];
          stop2 <= PWDATA[CTRL_STOP2];
          wlen  <= PWDATA[CTRL_WLEN +: 2];
        end
        REG_BAUDDIV: begin
          if (PSTRB[0]) bauddiv[7:0]  <= PWDATA[7:0];
          if (PSTRB[1]) bauddiv[15:8] <= PWDATA[15:8];
        end
        REG_IRQEN: if (PSTRB[0]) irqen <= PWDATA[2:0];
        REG_RXTHR: if (PSTRB[0]) rxthr <= PWDATA[7:0];
        default: ;
      endcase
    end
  end

  // Sticky error flags: hardware set wins over a same-cycle W1C
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      perr <= 1'b0; ferr <= 1'b0; ovr <= 1'b0;
    end else begin
      perr <= (perr & ~(stat_w1c & PWDATA[STAT_PERR])) | perr_set_c;
      ferr <= (ferr & ~(stat_w1c & PWDATA[STAT_FERR])) | ferr_set_c;
      ovr  <= (ovr  & ~(stat_w1c & PWDATA[STAT_OVR]))  | ovr_set_c;
    end
  end

  // Baud divider: one-cycle tick when count reaches BAUDDIV, restarted by any BAUDDIV write
  assign tick = (baud_cnt == bauddiv);
  always_ff @(posedge PCLK) begin
    if (PRESET || baud_wr_c || tick) baud_cnt <= '0;
    else                             baud_cnt <= baud_cnt + 16'd1;
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .LVL_W(LVL_W)) u_tx_fifo (
    .clk(PCLK), .rst(PRESET), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .wdata(PWDATA[7:0]), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .LVL_W(LVL_W)) u_rx_fifo (
    .clk(PCLK), .rst(PRESET), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .wdata(rx_byte_c), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  // TX frame timing; a new frame may start straight out of the last stop tick
  assign tx_bit_end_c  = tick & (tx_tcnt == 5'd15);
  assign tx_stop_end_c = tick & (tx_tcnt == (tx_stop2 ? 5'd31 : 5'd15));
  assign tx_load_c     = en & ~tx_empty &
                         ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_stop_end_c));
  assign tx_pop        = tx_load_c;
  assign o_uart_tx     = tx_line;

  // TX engine: shifts the popped byte out LSB first with registered line output
  always_ff @(posedge PCLK) begin
    if (PRESET || !en) begin
      tx_state <= TX_IDLE; tx_line <= 1'b1; tx_tcnt <= '0; tx_bcnt <= '0;
      if (PRESET) begin
        tx_shreg <= '0; tx_par <= 1'b0; tx_wlen <= WLEN_8; tx_pen <= 1'b0; tx_stop2 <= 1'b0;
      end
    end else if (tx_load_c) begin
      tx_state <= TX_START; tx_line <= 1'b0; tx_tcnt <= '0; tx_bcnt <= '0;
      tx_shreg <= tx_head;
      tx_par   <= calc_parity(tx_head, wlen, podd);
      tx_wlen  <= wlen; tx_pen <= pen; tx_stop2 <= stop2;
    end else begin
      case (tx_state)
        TX_START: if (tick) begin
          if (tx_bit_end_c) begin
            tx_state <= TX_DATA; tx_tcnt <= '0;
            tx_line <= tx_shreg[0]; tx_shreg <= tx_shreg >> 1;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        TX_DATA: if (tick) begin
          if (tx_bit_end_c) begin
            tx_tcnt <= '0;
            if (tx_bcnt == 3'(tx_wlen) + 3'd4) begin
              tx_state <= tx_pen ? TX_PARITY : TX_STOP;
              tx_line  <= tx_pen ? tx_par : 1'b1;
            end else begin
              tx_bcnt <= tx_bcnt + 3'd1;
              tx_line <= tx_shreg[0]; tx_shreg <= tx_shreg >> 1;
            end
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        TX_PARITY: if (tick) begin
          if (tx_bit_end_c) begin
            tx_state <= TX_STOP; tx_tcnt <= '0; tx_line <= 1'b1;
          end else tx_tcnt <= tx_tcnt + 5'd1;
        end
        TX_STOP: if (tx_stop_end_c) begin
          tx_state <= TX_IDLE; tx_tcnt <= '0;
        end else if (tick) tx_tcnt <= tx_tcnt + 5'd1;
        default: tx_line <= 1'b1;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous RX pin, idles high
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= i_uart_rx; rx_s2 <= rx_s1;
    end
  end

  // RX sample strobes, error detection and push of the zero-extended byte
  assign rx_mid_c   = tick & (rx_tcnt == 4'd15);
  assign rx_stop_c  = en & (rx_state == RX_STOP) & rx_mid_c;
  assign perr_set_c = en & (rx_state == RX_PARITY) & rx_mid_c & (rx_s2 != (rx_par ^ rx_podd));
  assign ferr_set_c = rx_stop_c & ~rx_s2;
  assign ovr_set_c  = rx_stop_c & rx_full & ~rx_pop;
  assign rx_push    = rx_stop_c;
  assign rx_byte_c  = rx_shreg >> (3'd3 - 3'(rx_wlen));

  // RX engine: start validated mid-bit, then one sample every 16 ticks
  always_ff @(posedge PCLK) begin
    if (PRESET || !en) begin
      rx_state <= RX_IDLE; rx_tcnt <= '0; rx_bcnt <= '0;
      if (PRESET) begin
        rx_shreg <= '0; rx_par <= 1'b0; rx_wlen <= WLEN_8; rx_pen <= 1'b0; rx_podd <= 1'b0;
      end
    end else begin
      case (rx_state)
        RX_IDLE: if (!rx_s2) begin
          rx_state <= RX_START; rx_tcnt <= '0; rx_bcnt <= '0; rx_shreg <= '0; rx_par <= 1'b0;
          rx_wlen <= wlen; rx_pen <= pen; rx_podd <= podd;
        end
        RX_START: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA; rx_tcnt <= '0;
          end else rx_tcnt <= rx_tcnt + 4'd1;
        end
        RX_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_mid_c) begin
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
            rx_par   <= rx_par ^ rx_s2;
            if (rx_bcnt == 3'(rx_wlen) + 3'd4) rx_state <= rx_pen ? RX_PARITY : RX_STOP;
            else                               rx_bcnt <= rx_bcnt + 3'd1;
          end
        end
        RX_PARITY: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_mid_c) rx_state <= RX_STOP;
        end
        RX_STOP: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_mid_c) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Registered level interrupts
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irqs1_rxuart <= 1'b0; irqs2_txuart <= 1'b0;
    end else begin
      irqs1_rxuart <= (irqen[0] & (8'(rx_level) >= rxthr) & (rxthr != 8'd0)) |
                      (irqen[2] & (perr | ferr | ovr));
      irqs2_txuart <= irqen[1] & tx_empty & ~tbusy;
    end
  end

endmodule
